// File: rtl/exe_pkg.sv
// Shared encodings for the MIPS32 execute stage: ALU type/op codes and divider FSM states.
package exe_pkg;

    localparam logic [2:0] ALUTYPE_NOP   = 3'b000;
    localparam logic [2:0] ALUTYPE_ARITH = 3'b001;
    localparam logic [2:0] ALUTYPE_LOGIC = 3'b010;
    localparam logic [2:0] ALUTYPE_MOVE  = 3'b011;
    localparam logic [2:0] ALUTYPE_SHIFT = 3'b100;
    localparam logic [2:0] ALUTYPE_JUMP  = 3'b101;

    localparam logic [7:0] OP_LUI   = 8'h05;
    localparam logic [7:0] OP_MFHI  = 8'h0C;
    localparam logic [7:0] OP_MFLO  = 8'h0D;
    localparam logic [7:0] OP_SLL   = 8'h11;
    localparam logic [7:0] OP_MULT  = 8'h14;
    localparam logic [7:0] OP_DIV   = 8'h16;
    localparam logic [7:0] OP_ADD   = 8'h18;
    localparam logic [7:0] OP_ADDIU = 8'h19;
    localparam logic [7:0] OP_SUBU  = 8'h1B;
    localparam logic [7:0] OP_AND   = 8'h1C;
    localparam logic [7:0] OP_ORI   = 8'h1D;
    localparam logic [7:0] OP_SLT   = 8'h26;
    localparam logic [7:0] OP_SLTIU = 8'h27;
    localparam logic [7:0] OP_JAL   = 8'h2E;
    localparam logic [7:0] OP_LB    = 8'h90;
    localparam logic [7:0] OP_LW    = 8'h93;
    localparam logic [7:0] OP_SB    = 8'h98;
    localparam logic [7:0] OP_SW    = 8'h9B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative signed restoring divider (one quotient bit per cycle).
// Optional DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module div_iter
    import exe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic          qneg_q, qneg_d, rneg_q, rneg_d;

    logic [31:0] dvd_abs, dvs_abs, diff;
    logic [32:0] shifted;
    logic        ge, early;

    assign dvd_abs = abs32(dividend);
    assign dvs_abs = abs32(divisor);
    // Partial remainder stays below the divisor, so the 32-bit difference is exact when ge.
    assign shifted = {rem_q, quo_q[31]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[31:0] - dvs_q;

`ifdef DIV_EARLY_EXIT_EN
    assign early = dvd_abs < dvs_abs;
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else if (early) begin
                        quo_d   = '0;
                        rem_d   = dividend;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else begin
                        quo_d   = dvd_abs;
                        rem_d   = '0;
                        dvs_d   = dvs_abs;
                        qneg_d  = dividend[31] ^ divisor[31];
                        rneg_d  = dividend[31];
                        cnt_d   = '0;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                quo_d = {quo_q[30:0], ge};
                rem_d = ge ? diff : shifted[31:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (!hold) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy      = ((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = qneg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = rneg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: ALU, HI/LO forwarding, single-cycle MULT, iterative DIV with stall.
// Optional DIV_EARLY_EXIT_EN enables the divider short-cut for |dividend| < |divisor|.
module exe_stage
    import exe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  exe_alutype_i,
    input  logic [7:0]  exe_aluop_i,
    input  logic [31:0] exe_src1_i,
    input  logic [31:0] exe_src2_i,
    input  logic [4:0]  exe_wa_i,
    input  logic        exe_wreg_i,
    input  logic        exe_mreg_i,
    input  logic        exe_whilo_i,
    input  logic [31:0] exe_din_i,
    input  logic [31:0] exe_ret_addr_i,
    input  logic        exe_hold_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem2exe_whilo,
    input  logic        wb2exe_whilo,
    input  logic [63:0] mem2exe_hilo,
    input  logic [63:0] wb2exe_hilo,
    output logic [7:0]  exe_aluop_o,
    output logic [4:0]  exe_wa_o,
    output logic        exe_wreg_o,
    output logic        exe_mreg_o,
    output logic        exe_whilo_o,
    output logic [31:0] exe_din_o,
    output logic [31:0] exe_wd_o,
    output logic [63:0] exe_hilo_o,
    output logic        stallreq_exe
);
    logic [31:0] hi_fwd, lo_fwd, wd, quo, rem;
    logic [63:0] hilo, prod;
    logic        div_start, div_busy, div_done;

    assign div_start = (exe_aluop_i == OP_DIV);
    assign prod = $signed({{32{exe_src1_i[31]}}, exe_src1_i}) *
                  $signed({{32{exe_src2_i[31]}}, exe_src2_i});

    div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (exe_src1_i),
        .divisor   (exe_src2_i),
        .hold      (exe_hold_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // Youngest pending HI/LO write wins: MEM over WB over architectural.
    always_comb begin
        hi_fwd = hi_i;
        lo_fwd = lo_i;
        if (mem2exe_whilo) begin
            hi_fwd = mem2exe_hilo[63:32];
            lo_fwd = mem2exe_hilo[31:0];
        end else if (wb2exe_whilo) begin
            hi_fwd = wb2exe_hilo[63:32];
            lo_fwd = wb2exe_hilo[31:0];
        end
    end

    always_comb begin
        wd = '0;
        case (exe_alutype_i)
            ALUTYPE_ARITH: begin
                case (exe_aluop_i)
                    OP_ADD, OP_ADDIU, OP_LB, OP_LW, OP_SB, OP_SW: wd = exe_src1_i + exe_src2_i;
                    OP_SUBU:  wd = exe_src1_i - exe_src2_i;
                    OP_SLT:   wd = {31'd0, $signed(exe_src1_i) < $signed(exe_src2_i)};
                    OP_SLTIU: wd = {31'd0, exe_src1_i < exe_src2_i};
                    default:  wd = '0;
                endcase
            end
            ALUTYPE_LOGIC: begin
                case (exe_aluop_i)
                    OP_AND:  wd = exe_src1_i & exe_src2_i;
                    OP_ORI:  wd = exe_src1_i | exe_src2_i;
                    OP_LUI:  wd = exe_src2_i;
                    default: wd = '0;
                endcase
            end
            ALUTYPE_MOVE: begin
                case (exe_aluop_i)
                    OP_MFHI: wd = hi_fwd;
                    OP_MFLO: wd = lo_fwd;
                    default: wd = '0;
                endcase
            end
            ALUTYPE_SHIFT: wd = (exe_aluop_i == OP_SLL) ? (exe_src2_i << exe_src1_i[4:0]) : '0;
            ALUTYPE_JUMP:  wd = (exe_aluop_i == OP_JAL) ? exe_ret_addr_i : '0;
            default:       wd = '0;
        endcase
    end

    always_comb begin
        hilo = '0;
        if (exe_aluop_i == OP_MULT)                hilo = prod;
        else if ((exe_aluop_i == OP_DIV) && div_done) hilo = {rem, quo};
    end

    // Reset forces every output low immediately, including the combinational paths.
    always_comb begin
        exe_aluop_o  = '0;
        exe_wa_o     = '0;
        exe_wreg_o   = 1'b0;
        exe_mreg_o   = 1'b0;
        exe_whilo_o  = 1'b0;
        exe_din_o    = '0;
        exe_wd_o     = '0;
        exe_hilo_o   = '0;
        stallreq_exe = 1'b0;
        if (rst_n) begin
            exe_aluop_o  = exe_aluop_i;
            exe_wa_o     = exe_wa_i;
            exe_wreg_o   = exe_wreg_i;
            exe_mreg_o   = exe_mreg_i;
            exe_whilo_o  = exe_whilo_i;
            exe_din_o    = exe_din_i;
            exe_wd_o     = wd;
            exe_hilo_o   = hilo;
            stallreq_exe = div_busy;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized instruction stream vs. a behavioural model.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  exe_alutype_i = '0;
    logic [7:0]  exe_aluop_i = '0;
    logic [31:0] exe_src1_i = '0, exe_src2_i = '0;
    logic [4:0]  exe_wa_i = '0;
    logic        exe_wreg_i = 1'b0, exe_mreg_i = 1'b0, exe_whilo_i = 1'b0;
    logic [31:0] exe_din_i = '0, exe_ret_addr_i = '0;
    logic        exe_hold_i = 1'b0;
    logic [31:0] hi_i = '0, lo_i = '0;
    logic        mem2exe_whilo = 1'b0, wb2exe_whilo = 1'b0;
    logic [63:0] mem2exe_hilo = '0, wb2exe_hilo = '0;
    logic [7:0]  exe_aluop_o;
    logic [4:0]  exe_wa_o;
    logic        exe_wreg_o, exe_mreg_o, exe_whilo_o;
    logic [31:0] exe_din_o, exe_wd_o;
    logic [63:0] exe_hilo_o;
    logic        stallreq_exe;

    exe_stage dut (
        .clk(clk), .rst_n(rst_n),
        .exe_alutype_i(exe_alutype_i), .exe_aluop_i(exe_aluop_i),
        .exe_src1_i(exe_src1_i), .exe_src2_i(exe_src2_i),
        .exe_wa_i(exe_wa_i), .exe_wreg_i(exe_wreg_i), .exe_mreg_i(exe_mreg_i),
        .exe_whilo_i(exe_whilo_i), .exe_din_i(exe_din_i), .exe_ret_addr_i(exe_ret_addr_i),
        .exe_hold_i(exe_hold_i), .hi_i(hi_i), .lo_i(lo_i),
        .mem2exe_whilo(mem2exe_whilo), .wb2exe_whilo(wb2exe_whilo),
        .mem2exe_hilo(mem2exe_hilo), .wb2exe_hilo(wb2exe_hilo),
        .exe_aluop_o(exe_aluop_o), .exe_wa_o(exe_wa_o), .exe_wreg_o(exe_wreg_o),
        .exe_mreg_o(exe_mreg_o), .exe_whilo_o(exe_whilo_o), .exe_din_o(exe_din_o),
        .exe_wd_o(exe_wd_o), .exe_hilo_o(exe_hilo_o), .stallreq_exe(stallreq_exe)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic int div_len(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (mag(a) < mag(b)) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] m_wd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi, lo;
        hi = mem2exe_whilo ? mem2exe_hilo[63:32] : (wb2exe_whilo ? wb2exe_hilo[63:32] : hi_i);
        lo = mem2exe_whilo ? mem2exe_hilo[31:0]  : (wb2exe_whilo ? wb2exe_hilo[31:0]  : lo_i);
        case (op)
            8'h18, 8'h19, 8'h90, 8'h93, 8'h98, 8'h9B: return a + b;
            8'h1B: return a - b;
            8'h26: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8'h27: return (a < b) ? 32'd1 : 32'd0;
            8'h1C: return a & b;
            8'h1D: return a | b;
            8'h05: return b;
            8'h11: return b << a[4:0];
            8'h2E: return exe_ret_addr_i;
            8'h0C: return hi;
            8'h0D: return lo;
            default: return 32'd0;
        endcase
    endfunction

    // Age of the DIV currently sitting in EXE, in cycles since it arrived.
    int          age = 0;
    int          len = 0;
    logic [31:0] da = '0, db = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_wd", exe_wd_o, 0);
            check("rst_hilo", exe_hilo_o, 0);
            check("rst_stall", stallreq_exe, 0);
            check("rst_pass", {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_din_o}, 0);
            age = 0;
        end else begin
            check("pass", {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_din_o},
                  {exe_aluop_i, exe_wa_i, exe_wreg_i, exe_mreg_i, exe_whilo_i, exe_din_i});
            if (exe_aluop_i == 8'h16) begin
                if (age == 0) begin
                    da = exe_src1_i;
                    db = exe_src2_i;
                end
                len = div_len(da, db);
                check("div_stall", stallreq_exe, (age < len) ? 1 : 0);
                if (age >= len) check("div_hilo", exe_hilo_o, div_res(da, db));
                if (age >= len && !exe_hold_i) age = 0;
                else age++;
            end else begin
                age = 0;
                check("alu_stall", stallreq_exe, 0);
                if (exe_aluop_i == 8'h14)
                    check("mult_hilo", exe_hilo_o,
                          64'(longint'($signed(exe_src1_i)) * longint'($signed(exe_src2_i))));
                else
                    check("alu_wd", exe_wd_o, m_wd(exe_aluop_i, exe_src1_i, exe_src2_i));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] ops [20] = '{8'h18, 8'h19, 8'h93, 8'h9B, 8'h1B, 8'h26, 8'h27, 8'h1C, 8'h1D, 8'h05,
                             8'h0C, 8'h0D, 8'h11, 8'h2E, 8'h14, 8'h16, 8'h00, 8'h90, 8'h98, 8'hFF};
    logic [2:0] tys [20] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                             3'd3, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exe_alutype_i = t;
        exe_aluop_i   = op;
        exe_src1_i    = a;
        exe_src2_i    = b;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallreq_exe) n++;
            else break;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 20);
            2: return 32'd0 - $urandom_range(0, 20);
            default: return ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx, h, dl;
        repeat (3) @(negedge clk);
        check("reset_stall_lit", stallreq_exe, 0);
        check("reset_hilo_lit", exe_hilo_o, 0);
        next();
        rst_n = 1'b1;

        issue(3'd1, 8'h18, 32'h7FFFFFFF, 32'd1);
        @(negedge clk);
        check("add_ovf_lit", exe_wd_o, 32'h80000000);
        check("add_stall_lit", stallreq_exe, 0);
        next(); issue(3'd1, 8'h26, 32'hFFFFFFFF, 32'd1);
        @(negedge clk); check("slt_lit", exe_wd_o, 32'd1);
        next(); issue(3'd1, 8'h27, 32'hFFFFFFFF, 32'd1);
        @(negedge clk); check("sltiu_lit", exe_wd_o, 32'd0);

        next();
        issue(3'd3, 8'h0C, 32'd0, 32'd0);
        hi_i = 32'd5; wb2exe_hilo = {32'd7, 32'd0}; mem2exe_hilo = {32'd9, 32'd0};
        wb2exe_whilo = 1'b1; mem2exe_whilo = 1'b1;
        @(negedge clk); check("mfhi_mem_lit", exe_wd_o, 32'd9);
        next(); mem2exe_whilo = 1'b0;
        @(negedge clk); check("mfhi_wb_lit", exe_wd_o, 32'd7);

        next(); issue(3'd1, 8'h16, 32'hFFFFFFF9, 32'd2);
        count_stall(n);
        check("div_m7_2_stall_lit", n, 33);
        check("div_m7_2_lit", exe_hilo_o, {32'hFFFFFFFF, 32'hFFFFFFFD});

        next(); issue(3'd1, 8'h16, 32'h12345678, 32'd0);
        count_stall(n);
        check("div0_stall_lit", n, 1);
        check("div0_lit", exe_hilo_o, {32'h12345678, 32'hFFFFFFFF});

        next(); issue(3'd1, 8'h16, 32'd100, 32'd7);
        repeat (33) next();
        exe_hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("div_hold_lit", exe_hilo_o, {32'd2, 32'd14});
            check("div_hold_stall_lit", stallreq_exe, 0);
            next();
        end
        exe_hold_i = 1'b0;

        next(); issue(3'd1, 8'h16, 32'd1000, 32'd3);
        repeat (11) next();
        rst_n = 1'b0;
        #1;
        check("async_rst_stall_lit", stallreq_exe, 0);
        check("async_rst_wd_lit", exe_wd_o, 0);
        @(negedge clk);
        next(); issue(3'd1, 8'h18, 32'd1, 32'd2); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle_lit", stallreq_exe, 0);
        check("post_rst_add_lit", exe_wd_o, 32'd3);

        next(); issue(3'd1, 8'h16, 32'd3, 32'd10);
        count_stall(n);
`ifdef DIV_EARLY_EXIT_EN
        check("div_3_10_stall_lit", n, 1);
`else
        check("div_3_10_stall_lit", n, 33);
`endif
        check("div_3_10_lit", exe_hilo_o, {32'd3, 32'd0});

        for (int k = 0; k < 300; k++) begin
            next();
            exe_hold_i = 1'b0;
            idx = $urandom_range(0, 19);
            issue(tys[idx], ops[idx], rnd_opnd(), rnd_opnd());
            if ($urandom_range(0, 3) == 0) exe_src1_i = exe_src1_i & 32'h1F;
            exe_wa_i = 5'($urandom); exe_wreg_i = 1'($urandom); exe_mreg_i = 1'($urandom);
            exe_whilo_i = 1'($urandom); exe_din_i = $urandom; exe_ret_addr_i = $urandom;
            hi_i = $urandom; lo_i = $urandom;
            mem2exe_whilo = 1'($urandom); wb2exe_whilo = 1'($urandom);
            mem2exe_hilo = {$urandom, $urandom}; wb2exe_hilo = {$urandom, $urandom};
            if (ops[idx] == 8'h16) begin
                dl = div_len(exe_src1_i, exe_src2_i);
                for (int j = 0; j < dl; j++) begin
                    next();
                    exe_src1_i = $urandom;
                    exe_src2_i = $urandom;
                end
                h = $urandom_range(0, 2);
                for (int j = 0; j < h; j++) begin
                    exe_hold_i = 1'b1;
                    next();
                end
                exe_hold_i = 1'b0;
            end
        end
        next();
        issue(3'd0, 8'h00, 32'd0, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage MIPS32 pipeline. It consumes the ID/EXE pipeline register, which is loaded from the decode outputs (alutype, aluop, src1/src2, wa, wreg, mreg, whilo, din, ret_addr).
- Produces the ALU result, the 64-bit HI/LO write value and the EXE→ID forwarding signals.
- Contains a 32-cycle iterative signed divider with a stall request to the pipeline controller.

Parameters:
DIV_CYCLES, 32, number of restoring-division iterations (fixed by data width; not intended to be overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
exe_alutype_i  in  3  ALU type: 001 arith, 010 logic, 011 move, 100 shift, 101 jump/branch
exe_aluop_i  in  8  ALU opcode (values in package)
exe_src1_i  in  32  operand 1 (already forwarded in ID)
exe_src2_i  in  32  operand 2 / extended immediate
exe_wa_i  in  5  destination register
exe_wreg_i  in  1  register write enable
exe_mreg_i  in  1  load instruction
exe_whilo_i  in  1  HI/LO write enable
exe_din_i  in  32  store data
exe_ret_addr_i  in  32  PC+8 for jal
exe_hold_i  in  1  controller holds ID/EXE register this cycle
hi_i, lo_i  in  32 each  architectural HI/LO
mem2exe_whilo, wb2exe_whilo  in  1 each  HI/LO write pending in MEM / WB
mem2exe_hilo, wb2exe_hilo  in  64 each  pending {HI,LO} values
exe_aluop_o  out  8  passthrough
exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_din_o  out  5/1/1/1/32  passthrough
exe_wd_o  out  32  result; also EXE→ID forward data
exe_hilo_o  out  64  {HI,LO} to write
stallreq_exe  out  1  divider busy

Behaviour:
- rst_n low, asynchronous: FSM to IDLE, counter/partial registers 0, all outputs 0.
- Combinational results by aluop:
  - ADD/ADDIU/LB/LW/SB/SW: src1+src2 (mod 2^32, no overflow trap).
  - SUBU: src1-src2.
  - SLT: signed compare → 1/0. SLTIU: unsigned compare → 1/0.
  - AND: src1&src2. ORI: src1|src2. LUI: src2.
  - SLL: src2 << src1[4:0].
  - JAL: exe_wd_o = exe_ret_addr_i.
  - MULT: exe_hilo_o = signed 64-bit src1*src2, single cycle.
  - Unknown aluop: exe_wd_o = 0.
- MFHI/MFLO read HI/LO with priority MEM pending > WB pending > hi_i/lo_i.
- FSM states IDLE, BUSY, DONE:
  - IDLE: DIV in EXE and not early-exit → latch |src1|, |src2| and both signs, count=0, go to BUSY. stallreq_exe=1 combinationally in this same cycle.
  - BUSY: one restoring step per cycle; count increments 0..31. stallreq_exe=1. The step with count==31 transitions to DONE.
  - DONE: stallreq_exe=0; exe_hilo_o = {remainder, quotient} with signs restored:
    - quotient negative iff the two signs differ;
    - remainder takes the dividend's sign.
  - DONE with exe_hold_i=1: stay in DONE, result held. Otherwise go to IDLE.
- Latency: DIV occupies EXE for 34 cycles (1 setup + 32 steps + 1 DONE); stallreq_exe is high for 33 of them.
- Divide by zero: no iteration. Go directly IDLE→DONE with quotient 0xFFFFFFFF and remainder = src1; stallreq_exe high for 1 cycle.
- A non-DIV instruction arriving in EXE while in IDLE never asserts stallreq_exe.
- Reset mid-division aborts immediately; no HI/LO write.
- Operands are sampled only in IDLE; changes on exe_src*_i during BUSY are ignored.

Optional Feature:
DIV_EARLY_EXIT_EN
- Defined: in IDLE, if |src1| < |src2| (divisor nonzero), go directly to DONE with quotient 0 and remainder = src1; stallreq_exe high 1 cycle.
- Undefined: every nonzero-divisor DIV takes the full 32 steps.

Decomposition:
- Package exe_pkg holds:
  - the alutype codes;
  - the aluop constants: ADD 0x18, SUBU 0x1B, SLT 0x26, AND 0x1C, MULT 0x14, DIV 0x16, MFHI 0x0C, MFLO 0x0D, SLL 0x11, ORI 0x1D, LUI 0x05, ADDIU 0x19, SLTIU 0x27, LB 0x90, LW 0x93, SB 0x98, SW 0x9B, JAL 0x2E;
  - the FSM state enum.
- Sub-module div_iter: the FSM, counter and restoring datapath, with ports start, dividend, divisor, hold, busy, done, quotient, remainder. The ALU muxing stays in exe_stage.

Test Plan:
- ADD src1=0x7FFFFFFF, src2=1 → exe_wd_o=0x80000000, stallreq_exe=0.
- SLT src1=0xFFFFFFFF, src2=1 → 1; SLTIU same operands → 0.
- MFHI with hi_i=5, wb2exe HI=7, mem2exe HI=9 (both pending) → 9; with mem2exe_whilo=0 → 7.
- DIV src1=-7, src2=2 → stallreq_exe high 33 cycles, then exe_hilo_o={0xFFFFFFFF, 0xFFFFFFFD}.
- DIV src2=0 → 1-cycle stall, quotient 0xFFFFFFFF, remainder src1. Then DIV 100/7 with exe_hold_i=1 during DONE → result {2,14} held 3 cycles, no restart.
- rst_n pulsed low at BUSY count=10 → outputs 0 asynchronously, FSM IDLE. With DIV_EARLY_EXIT_EN, DIV 3/10 → 1-cycle stall, {3,0}.
